ramio_ctrl: RTL and testbench

Initiator side of the single-port block RAM interface. It accepts byte-addressed load/store requests (byte, half-word, word) from the core over a valid/ready handshake. It drives a word-addressed single-port BRAM that has one-cycle registered read latency and a synchronous write. Sub-word stores are performed as read-modify-write; loads are lane-extracted and optionally sign-extended.

---
 rtl/ramio_ctrl_if.sv | 25 ++
 rtl/ramio_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ramio_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramio_ctrl_if.sv
// rtl/ramio_ctrl_if.sv - request/response bus between the core and ramio_ctrl
interface ramio_ctrl_if #(
    parameter int ADDRESS_BITWIDTH = 16
) ();
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [1:0]                  req_size;
    logic                        req_signed;
    logic [ADDRESS_BITWIDTH+1:0] req_address;
    logic [31:0]                 req_data;
    logic                        rsp_valid;
    logic [31:0]                 rsp_data;
    logic                        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/ramio_ctrl.sv
// rtl/ramio_ctrl.sv - byte-addressed load/store initiator for a word-wide single-port BRAM; optional RAMIO_ALIGN_CHECK_EN
module ramio_ctrl #(
    parameter int ADDRESS_BITWIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ramio_ctrl_if.slave                 bus,
    output logic                        ram_write_enable,
    output logic [ADDRESS_BITWIDTH-1:0] ram_address,
    output logic [31:0]                 ram_data_out,
    input  logic [31:0]                 ram_data_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Request fields captured at acceptance; only the low half of store data
    // is needed later because word stores take req_data directly.
    logic        write_q,  write_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q,   lane_d;
    logic [15:0] data_q,   data_d;

    logic                        ram_we_d;
    logic [ADDRESS_BITWIDTH-1:0] ram_address_d;
    logic [31:0]                 ram_data_out_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [31:0]                 rsp_data_q,  rsp_data_d;
    logic                        misaligned;

    // Size code bit 1 selects a full word (code 11 folds onto word when unchecked).
    function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (sz[1])
            r = w;
        else if (sz[0])
            r = {{16{sg & h[15]}}, h};
        else
            r = {{24{sg & b[7]}}, b};
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [15:0] d,
                                               input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        if (sz[0]) begin
            if (lane[1]) m[31:16] = d;
            else         m[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end
        return m;
    endfunction

`ifdef RAMIO_ALIGN_CHECK_EN
    assign misaligned = (bus.req_size == 2'b11)
                     || (bus.req_size == 2'b01 && bus.req_address[0])
                     || (bus.req_size == 2'b10 && bus.req_address[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Next-state and next-register values; everything defaults to hold, with
    // the write strobe and response pulse defaulting low so they last one cycle.
    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        size_d         = size_q;
        signed_d       = signed_q;
        lane_d         = lane_q;
        data_d         = data_q;
        ram_we_d       = 1'b0;
        ram_address_d  = ram_address;
        ram_data_out_d = ram_data_out;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'd0;
                    end else begin
                        write_d       = bus.req_write;
                        size_d        = bus.req_size;
                        signed_d      = bus.req_signed;
                        lane_d        = bus.req_address[1:0];
                        data_d        = bus.req_data[15:0];
                        ram_address_d = bus.req_address[ADDRESS_BITWIDTH+1:2];
                        if (bus.req_write && bus.req_size[1]) begin
                            ram_data_out_d = bus.req_data;
                            ram_we_d       = 1'b1;
                            state_d        = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (write_q) begin
                    ram_data_out_d = merge_lane(ram_data_in, data_q, size_q, lane_q);
                    ram_we_d       = 1'b1;
                    state_d        = WRITE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = extract_lane(ram_data_in, size_q, lane_q, signed_q);
                    state_d     = IDLE;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = 32'd0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            lane_q           <= 2'b00;
            data_q           <= 16'd0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_out     <= 32'd0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= 32'd0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            lane_q           <= lane_d;
            data_q           <= data_d;
            ram_write_enable <= ram_we_d;
            ram_address      <= ram_address_d;
            ram_data_out     <= ram_data_out_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
        end
    end

`ifdef RAMIO_ALIGN_CHECK_EN
    logic rsp_error_q;

    // Error flag is refreshed with every response and holds between responses;
    // a response raised from IDLE can only be a rejection.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rsp_error_q <= 1'b0;
        else if (rsp_valid_d)
            rsp_error_q <= (state_q == IDLE) && misaligned;
    end

    assign bus.rsp_error = rsp_error_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_ramio_ctrl.sv
// tb/tb_ramio_ctrl.sv - self-checking bench for ramio_ctrl with BRAM model and reference memory
module tb_ramio_ctrl;
    localparam int AW = 16;
`ifdef RAMIO_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data_out;
    logic [31:0]   ram_data_in;

    always #5 clk = ~clk;

    ramio_ctrl_if #(.ADDRESS_BITWIDTH(AW)) bus ();

    ramio_ctrl #(.ADDRESS_BITWIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_out     (ram_data_out),
        .ram_data_in      (ram_data_in)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:15];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;
    int checks = 0;
    int errors = 0;

    // BRAM: registered read, synchronous write, plus a preload port for the bench
    always @(posedge clk) begin
        if (pre_en)
            mem[{12'd0, pre_idx}] <= pre_val;
        else if (ram_write_enable)
            mem[ram_address] <= ram_data_out;
        ram_data_in <= mem[ram_address];
    end

    function automatic bit is_reject(input logic [1:0] sz, input logic [17:0] a);
        return CHK && (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_of(input logic [1:0] sz, input logic [17:0] a);
        return (sz == 2'd0) ? int'(a[1:0]) : (sz == 2'd1) ? (a[1] ? 2 : 0) : 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] wv, input logic [1:0] sz,
                                               input logic sg, input logic [17:0] a);
        int nb;
        logic [31:0] v;
        logic [31:0] mask;
        nb = nbytes(sz);
        v = wv >> (8 * lane_of(sz, a));
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v = v & mask;
            if (sg && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [17:0] a, input logic [31:0] d);
        int nb;
        int sh;
        logic [31:0] mask;
        nb = nbytes(sz);
        if (nb == 4) return d;
        sh = 8 * lane_of(sz, a);
        mask = ((32'h1 << (8 * nb)) - 32'h1) << sh;
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One transaction: returns the response plus its latency and write-strobe
    // activity counted in cycles after the acceptance edge (cycle k = 0).
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [17:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic re,
                         output int lat, output int we_cnt, output int we_first);
        int n;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_size    = sz;
        bus.req_signed  = sg;
        bus.req_address = a;
        bus.req_data    = d;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = -1;
        we_cnt = 0;
        we_first = -1;
        rd = 32'hx;
        re = 1'bx;
        for (int c = 0; c < 12; c++) begin
            if (ram_write_enable) begin
                we_cnt++;
                if (we_first < 0) we_first = c;
            end
            if (bus.rsp_valid) begin
                lat = c;
                rd = bus.rsp_data;
                re = bus.rsp_error;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_address = '0;
        bus.req_data = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b expected 0", bus.rsp_error); end
        checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_write_enable); end
        checks++; if (ram_address !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_address); end
        checks++; if (ram_data_out !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", ram_data_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic re; int lat, wc, wf;
        issue(1'b1, 2'd2, 1'b0, 18'h0008, 32'hDEADBEEF, rd, re, lat, wc, wf);
        ref_mem[2] = 32'hDEADBEEF;
        checks++; if (lat !== 1) begin errors++; $display("FAIL word_store_lat: got %0d expected 1", lat); end
        checks++; if (wf !== 0 || wc !== 1) begin errors++; $display("FAIL word_store_we: first %0d count %0d expected 0/1", wf, wc); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL word_store_rsp: got %h expected 0", rd); end
        checks++; if (mem[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_mem: got %h expected deadbeef", mem[2]); end
        issue(1'b0, 2'd2, 1'b1, 18'h0008, 32'd0, rd, re, lat, wc, wf);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data: got %h expected deadbeef", rd); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL word_load_we: got %0d expected 0", wc); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic re; int lat, wc, wf;
        preload(0, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 18'h0002, 32'h000000AA, rd, re, lat, wc, wf);
        ref_mem[0] = 32'h11AA3344;
        checks++; if (mem[0] !== 32'h11AA3344) begin errors++; $display("FAIL byte_store_mem: got %h expected 11aa3344", mem[0]); end
        checks++; if (wf !== 2 || wc !== 1) begin errors++; $display("FAIL byte_store_we: first %0d count %0d expected 2/1", wf, wc); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL byte_store_lat: got %0d expected 3", lat); end
        issue(1'b0, 2'd0, 1'b1, 18'h0002, 32'd0, rd, re, lat, wc, wf);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL byte_load_signed: got %h expected ffffffaa", rd); end
        issue(1'b0, 2'd0, 1'b0, 18'h0002, 32'd0, rd, re, lat, wc, wf);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL byte_load_unsigned: got %h expected 000000aa", rd); end
        issue(1'b0, 2'd1, 1'b1, 18'h0002, 32'd0, rd, re, lat, wc, wf);
        checks++; if (rd !== 32'h000011AA) begin errors++; $display("FAIL half_load_signed: got %h expected 000011aa", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic re; int lat, wc, wf;
        logic [31:0] old, exp_w;
        old = ref_mem[0];
        exp_w = CHK ? old : {16'h5566, old[15:0]};
        issue(1'b1, 2'd1, 1'b0, 18'h0003, 32'h00005566, rd, re, lat, wc, wf);
        ref_mem[0] = exp_w;
        checks++; if (lat !== (CHK ? 0 : 3)) begin errors++; $display("FAIL misalign_lat: got %0d expected %0d", lat, CHK ? 0 : 3); end
        checks++; if (re !== CHK) begin errors++; $display("FAIL misalign_err: got %b expected %b", re, CHK); end
        checks++; if (wc !== (CHK ? 0 : 1)) begin errors++; $display("FAIL misalign_we: got %0d expected %0d", wc, CHK ? 0 : 1); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misalign_data: got %h expected 0", rd); end
        @(posedge clk); #1;
        checks++; if (ram_write_enable !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL misalign_after: we %b rsp_valid %b expected 0/0", ram_write_enable, bus.rsp_valid); end
        checks++; if (mem[0] !== exp_w) begin errors++; $display("FAIL misalign_mem: got %h expected %h", mem[0], exp_w); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic re; int lat, wc, wf;
        int seen;
        preload(1, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_address = 18'h0005; bus.req_data = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_error !== 1'b0) begin
            errors++; $display("FAIL midreset_rsp: ready %b valid %b data %h err %b expected 1/0/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error); end
        checks++; if (ram_write_enable !== 1'b0 || ram_address !== '0 || ram_data_out !== 32'd0) begin
            errors++; $display("FAIL midreset_ram: we %b addr %h wdata %h expected 0/0/0", ram_write_enable, ram_address, ram_data_out); end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid || ram_write_enable) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
        checks++; if (mem[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_mem: got %h expected cafef00d", mem[1]); end
        issue(1'b0, 2'd1, 1'b0, 18'h0006, 32'd0, rd, re, lat, wc, wf);
        checks++; if (rd !== 32'h0000CAFE || lat !== 2) begin errors++; $display("FAIL midreset_next: got %h lat %0d expected 0000cafe lat 2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        int acc_edge [3];
        bit rdy_log [16];
        logic [31:0] exp_q [$];
        logic [31:0] e;
        int acc, rsp_cnt, widx;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        acc = 0;
        rsp_cnt = 0;
        @(negedge clk);
        widx = $urandom_range(0, 15);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_address = 18'(widx * 4);
        for (int ed = 0; ed < 14; ed++) begin
            rdy_log[ed] = bus.req_ready;
            if (bus.req_ready && bus.req_valid) begin
                acc_edge[acc] = ed;
                exp_q.push_back(ref_mem[widx]);
            end
            @(posedge clk); #1;
            if (rdy_log[ed] && bus.req_valid) begin
                acc++;
                widx = $urandom_range(0, 15);
                bus.req_address = 18'(widx * 4);
                if (acc == 3) bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                checks++; if (bus.rsp_data !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", bus.rsp_data, e); end
            end
            @(negedge clk);
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
        checks++; if (rsp_cnt !== 3) begin errors++; $display("FAIL b2b_responses: got %0d expected 3", rsp_cnt); end
        if (acc == 3) begin
            checks++; if (acc_edge[1] - acc_edge[0] !== 3 || acc_edge[2] - acc_edge[1] !== 3) begin
                errors++; $display("FAIL b2b_spacing: edges %0d %0d %0d expected spacing 3", acc_edge[0], acc_edge[1], acc_edge[2]); end
            for (int j = 0; j < 3; j++) begin
                checks++; if (rdy_log[acc_edge[j]+1] !== 1'b0 || rdy_log[acc_edge[j]+2] !== 1'b0) begin
                    errors++; $display("FAIL b2b_ready_low: accept %0d ready %b %b expected 0 0", j, rdy_log[acc_edge[j]+1], rdy_log[acc_edge[j]+2]); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic re; int lat, wc, wf;
        logic w, sg, rej; logic [1:0] sz; logic [17:0] a; logic [31:0] d, exp_d;
        int widx, exp_lat;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            widx = $urandom_range(0, 15);
            a = 18'(widx * 4 + $urandom_range(0, 3));
            d = $urandom;
            rej = is_reject(sz, a);
            exp_lat = rej ? 0 : (!w ? 2 : (sz[1] ? 1 : 3));
            exp_d = (rej || w) ? 32'd0 : model_load(ref_mem[widx], sz, sg, a);
            if (w && !rej) ref_mem[widx] = model_store(ref_mem[widx], sz, a, d);
            issue(w, sz, sg, a, d, rd, re, lat, wc, wf);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, exp_lat); end
            checks++; if (rd !== exp_d) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, rd, exp_d); end
            checks++; if (re !== rej) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, re, rej); end
            checks++; if (wc !== ((w && !rej) ? 1 : 0)) begin errors++; $display("FAIL rand_we[%0d]: got %0d expected %0d", i, wc, (w && !rej) ? 1 : 0); end
            checks++; if (mem[widx] !== ref_mem[widx]) begin errors++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[widx], ref_mem[widx]); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
